// File: rtl/dcache_pkg.sv
// dcache_pkg: default data-array geometry and the FSM state encoding shared by the D-cache data array files
package dcache_pkg;
  localparam int WORD_W_D = 32;
  localparam int WORDS_PER_LINE_D = 8;
  localparam int SETS_D = 64;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, EVICT = 2'd2} state_e;
endpackage

// File: rtl/dcache_data_array_if.sv
// dcache_data_array_if: CPU access, refill and evict ports of the data array; master = controller/bus side, slave = array
interface dcache_data_array_if import dcache_pkg::*; #(
  parameter int WORD_W = WORD_W_D,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_D,
  parameter int SETS = SETS_D,
  localparam int OFF_W = $clog2(WORDS_PER_LINE),
  localparam int IDX_W = $clog2(SETS),
  localparam int BE_W = WORD_W / 8
) ();
  logic cpu_req;
  logic [BE_W-1:0] cpu_be;
  logic [IDX_W-1:0] cpu_index;
  logic [OFF_W-1:0] cpu_offset;
  logic [WORD_W-1:0] cpu_wdata;
  logic cpu_gnt;
  logic cpu_rvalid;
  logic [WORD_W-1:0] cpu_rdata;
  logic fill_start;
  logic [IDX_W-1:0] fill_index;
  logic fill_valid;
  logic [WORD_W-1:0] fill_data;
  logic fill_ready;
  logic fill_done;
  logic evict_start;
  logic [IDX_W-1:0] evict_index;
  logic evict_valid;
  logic [WORD_W-1:0] evict_data;
  logic evict_ready;
  logic evict_done;
  logic busy;
  modport master (
    output cpu_req, cpu_be, cpu_index, cpu_offset, cpu_wdata, fill_start, fill_index, fill_valid, fill_data,
           evict_start, evict_index, evict_ready,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, fill_ready, fill_done, evict_valid, evict_data, evict_done, busy
  );
  modport slave (
    input  cpu_req, cpu_be, cpu_index, cpu_offset, cpu_wdata, fill_start, fill_index, fill_valid, fill_data,
           evict_start, evict_index, evict_ready,
    output cpu_gnt, cpu_rvalid, cpu_rdata, fill_ready, fill_done, evict_valid, evict_data, evict_done, busy
  );
endinterface

// File: rtl/dcache_line_mem.sv
// dcache_line_mem: SETS x line storage; ports: byte-enable word write (i_bw_*), full-word write (i_fw_*), registered word read (i_rd_*/o_rd_data), combinational line read (i_ln_idx/o_ln_data)
module dcache_line_mem import dcache_pkg::*; #(
  parameter int WORD_W = WORD_W_D,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_D,
  parameter int SETS = SETS_D,
  localparam int OFF_W = $clog2(WORDS_PER_LINE),
  localparam int IDX_W = $clog2(SETS),
  localparam int BE_W = WORD_W / 8,
  localparam int LINE_W = WORD_W * WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              i_bw_en,
  input  logic [BE_W-1:0]   i_bw_be,
  input  logic [IDX_W-1:0]  i_bw_idx,
  input  logic [OFF_W-1:0]  i_bw_off,
  input  logic [WORD_W-1:0] i_bw_data,
  input  logic              i_fw_en,
  input  logic [IDX_W-1:0]  i_fw_idx,
  input  logic [OFF_W-1:0]  i_fw_off,
  input  logic [WORD_W-1:0] i_fw_data,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_rd_idx,
  input  logic [OFF_W-1:0]  i_rd_off,
  output logic [WORD_W-1:0] o_rd_data,
  input  logic [IDX_W-1:0]  i_ln_idx,
  output logic [LINE_W-1:0] o_ln_data
);
  logic [LINE_W-1:0] r_mem [SETS];
  always_ff @(posedge clk) begin
    if (i_bw_en)
      for (int b = 0; b < BE_W; b++)
        if (i_bw_be[b]) r_mem[i_bw_idx][int'(i_bw_off)*WORD_W + b*8 +: 8] <= i_bw_data[b*8 +: 8];
    if (i_fw_en) r_mem[i_fw_idx][int'(i_fw_off)*WORD_W +: WORD_W] <= i_fw_data;
  end
  always_ff @(posedge clk or negedge srst_n)
    if (!srst_n) o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_idx][int'(i_rd_off)*WORD_W +: WORD_W];
  assign o_ln_data = r_mem[i_ln_idx];
endmodule

// File: rtl/dcache_data_array.sv
// dcache_data_array: L1 D-cache data store; ports: clk, srst_n (async active-low), bus (slave: CPU access, line refill, line evict, busy)
module dcache_data_array import dcache_pkg::*; #(
  parameter int WORD_W = WORD_W_D,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_D,
  parameter int SETS = SETS_D,
  localparam int OFF_W = $clog2(WORDS_PER_LINE),
  localparam int IDX_W = $clog2(SETS),
  localparam int LINE_W = WORD_W * WORDS_PER_LINE
) (
  input logic clk,
  input logic srst_n,
  dcache_data_array_if.slave bus
);
  state_e r_state;
  logic [OFF_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic r_fill_done, r_rvalid;
  logic [LINE_W-1:0] r_buf, w_line;
  logic [WORD_W-1:0] w_rdata;
  logic w_gnt, w_last, w_fill_beat, w_evict_beat, w_snap;
  assign w_gnt = bus.cpu_req & (r_state == IDLE) & ~bus.evict_start & ~bus.fill_start;
  assign w_last = r_cnt == OFF_W'(WORDS_PER_LINE - 1);
  assign w_fill_beat = (r_state == FILL) & bus.fill_valid;
  assign w_evict_beat = (r_state == EVICT) & bus.evict_ready;
  assign w_snap = (r_state == IDLE) & bus.evict_start;
  assign bus.cpu_gnt = w_gnt;
  assign bus.cpu_rvalid = r_rvalid;
  assign bus.cpu_rdata = w_rdata;
  assign bus.fill_ready = r_state == FILL;
  assign bus.fill_done = r_fill_done;
  assign bus.evict_valid = r_state == EVICT;
  assign bus.evict_data = (r_state == EVICT) ? r_buf[int'(r_cnt)*WORD_W +: WORD_W] : '0;
  assign bus.evict_done = w_evict_beat & w_last;
  assign bus.busy = r_state != IDLE;
  dcache_line_mem #(.WORD_W(WORD_W), .WORDS_PER_LINE(WORDS_PER_LINE), .SETS(SETS)) u_mem (
    .clk(clk), .srst_n(srst_n),
    .i_bw_en(w_gnt & |bus.cpu_be), .i_bw_be(bus.cpu_be), .i_bw_idx(bus.cpu_index),
    .i_bw_off(bus.cpu_offset), .i_bw_data(bus.cpu_wdata),
    .i_fw_en(w_fill_beat), .i_fw_idx(r_idx), .i_fw_off(r_cnt), .i_fw_data(bus.fill_data),
    .i_rd_en(w_gnt & ~|bus.cpu_be), .i_rd_idx(bus.cpu_index), .i_rd_off(bus.cpu_offset), .o_rd_data(w_rdata),
    .i_ln_idx(bus.evict_index), .o_ln_data(w_line)
  );
  // the evicted line is frozen here so later array writes cannot alter beats still in flight
  always_ff @(posedge clk)
    if (w_snap) r_buf <= w_line;
  always_ff @(posedge clk or negedge srst_n)
    if (!srst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_fill_done <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_gnt & ~|bus.cpu_be;
      r_fill_done <= w_fill_beat & w_last;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_state <= bus.evict_start ? EVICT : bus.fill_start ? FILL : IDLE;
          if (bus.fill_start) r_idx <= bus.fill_index;
        end
        FILL, EVICT:
          if (w_fill_beat | w_evict_beat) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dcache_data_array.sv
// tb_dcache_data_array: directed checks of CPU access, refill, evict, start priority and reset abort
module tb_dcache_data_array;
  logic clk = 1'b0;
  logic srst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  dcache_data_array_if #(.WORD_W(32), .WORDS_PER_LINE(8), .SETS(64)) bus ();
  dcache_data_array #(.WORD_W(32), .WORDS_PER_LINE(8), .SETS(64)) dut (.clk(clk), .srst_n(srst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic idle_inputs;
    bus.cpu_req = 0; bus.cpu_be = '0; bus.cpu_index = '0; bus.cpu_offset = '0; bus.cpu_wdata = '0;
    bus.fill_start = 0; bus.fill_index = '0; bus.fill_valid = 0; bus.fill_data = '0;
    bus.evict_start = 0; bus.evict_index = '0; bus.evict_ready = 0;
  endtask

  task automatic cpu_write(input int idx, input int off, input logic [3:0] be, input logic [31:0] d);
    bus.cpu_req = 1; bus.cpu_be = be; bus.cpu_index = 6'(idx); bus.cpu_offset = 3'(off); bus.cpu_wdata = d;
    @(negedge clk);
    bus.cpu_req = 0; bus.cpu_be = '0;
  endtask

  task automatic cpu_read(input int idx, input int off, output logic v, output logic [31:0] d);
    bus.cpu_req = 1; bus.cpu_be = '0; bus.cpu_index = 6'(idx); bus.cpu_offset = 3'(off);
    @(negedge clk);
    bus.cpu_req = 0;
    v = bus.cpu_rvalid; d = bus.cpu_rdata;
  endtask

  task automatic test_reset;
    idle_inputs();
    srst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.cpu_gnt, bus.cpu_rvalid, bus.fill_ready, bus.fill_done, bus.evict_valid, bus.evict_done, bus.busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000000", {bus.cpu_gnt, bus.cpu_rvalid, bus.fill_ready, bus.fill_done, bus.evict_valid, bus.evict_done, bus.busy});
    end
    checks++;
    if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.cpu_rdata); end
    checks++;
    if (bus.evict_data !== 32'h0) begin errors++; $display("FAIL reset_evict_data got=%h exp=0", bus.evict_data); end
    @(negedge clk);
    srst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    bus.cpu_req = 1; bus.cpu_be = 4'hF; bus.cpu_index = 6'd5; bus.cpu_offset = 3'd3; bus.cpu_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got=%b exp=1", bus.cpu_gnt); end
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got=%b exp=0", bus.cpu_rvalid); end
    bus.cpu_be = 4'h0;
    #1;
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got=%b exp=1", bus.cpu_gnt); end
    @(negedge clk);
    bus.cpu_req = 0;
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_data got=%b/%h exp=1/deadbeef", bus.cpu_rvalid, bus.cpu_rdata);
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_hold got=%b/%h exp=0/deadbeef", bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  task automatic test_partial_write;
    logic v;
    logic [31:0] d;
    cpu_write(5, 4, 4'hF, 32'h11223344);
    cpu_write(5, 4, 4'b0100, 32'h00AA0000);
    cpu_read(5, 4, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'h11AA3344) begin errors++; $display("FAIL partial got=%b/%h exp=1/11aa3344", v, d); end
  endtask

  task automatic test_fill;
    int fd = 0;
    int gnt_bad = 0;
    logic v;
    logic [31:0] d;
    bus.fill_start = 1; bus.fill_index = 6'd9;
    @(negedge clk);
    bus.fill_start = 0;
    #1;
    checks++;
    if (bus.fill_ready !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL fill_enter ready/busy got=%b/%b exp=1/1", bus.fill_ready, bus.busy);
    end
    for (int i = 0; i < 8; i++) begin
      bus.cpu_req = 1; bus.cpu_be = '0; bus.fill_valid = 0;
      #1;
      if (bus.cpu_gnt !== 1'b0) gnt_bad++;
      @(negedge clk);
      fd += int'(bus.fill_done);
      bus.fill_valid = 1; bus.fill_data = 32'(32'h100 + i);
      #1;
      if (bus.cpu_gnt !== 1'b0) gnt_bad++;
      @(negedge clk);
      fd += int'(bus.fill_done);
    end
    bus.fill_valid = 0; bus.cpu_req = 0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL fill_exit busy got=%b exp=0", bus.busy); end
    repeat (2) begin @(negedge clk); fd += int'(bus.fill_done); end
    checks++;
    if (fd != 1) begin errors++; $display("FAIL fill_done_count got=%0d exp=1", fd); end
    checks++;
    if (gnt_bad != 0) begin errors++; $display("FAIL fill_gnt got=%0d grants exp=0", gnt_bad); end
    for (int i = 0; i < 8; i++) begin
      cpu_read(9, i, v, d);
      checks++;
      if (v !== 1'b1 || d !== 32'(32'h100 + i)) begin
        errors++; $display("FAIL fill_word%0d got=%b/%h exp=1/%h", i, v, d, 32'(32'h100 + i));
      end
    end
  endtask

  task automatic test_evict;
    int k = 0;
    bus.evict_start = 1; bus.evict_index = 6'd9; bus.evict_ready = 0;
    @(negedge clk);
    bus.evict_start = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      bus.evict_ready = (c % 2 == 0);
      #1;
      checks++;
      if (bus.evict_valid !== 1'b1 || bus.evict_data !== 32'(32'h100 + k)) begin
        errors++; $display("FAIL evict_beat%0d got=%b/%h exp=1/%h", k, bus.evict_valid, bus.evict_data, 32'(32'h100 + k));
      end
      checks++;
      if (bus.evict_done !== (bus.evict_ready && k == 7)) begin
        errors++; $display("FAIL evict_done beat%0d got=%b exp=%b", k, bus.evict_done, bus.evict_ready && k == 7);
      end
      if (bus.evict_ready) k++;
      @(negedge clk);
    end
    bus.evict_ready = 0;
    checks++;
    if (k != 8) begin errors++; $display("FAIL evict_timeout got=%0d beats exp=8", k); end
    checks++;
    if (bus.busy !== 1'b0 || bus.evict_valid !== 1'b0) begin
      errors++; $display("FAIL evict_exit busy/valid got=%b/%b exp=0/0", bus.busy, bus.evict_valid);
    end
  endtask

  task automatic test_priority;
    logic v;
    logic [31:0] d;
    bus.evict_start = 1; bus.evict_index = 6'd9; bus.fill_start = 1; bus.fill_index = 6'd3;
    bus.cpu_req = 1; bus.cpu_be = 4'hF; bus.cpu_index = 6'd9; bus.cpu_offset = 3'd0; bus.cpu_wdata = 32'hFFFFFFFF;
    #1;
    checks++;
    if (bus.cpu_gnt !== 1'b0) begin errors++; $display("FAIL prio_gnt got=%b exp=0", bus.cpu_gnt); end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (bus.evict_valid !== 1'b1 || bus.fill_ready !== 1'b0) begin
      errors++; $display("FAIL prio_state evict_valid/fill_ready got=%b/%b exp=1/0", bus.evict_valid, bus.fill_ready);
    end
    bus.evict_ready = 1;
    repeat (8) @(negedge clk);
    bus.evict_ready = 0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL prio_exit busy got=%b exp=0", bus.busy); end
    cpu_read(9, 0, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'h100) begin errors++; $display("FAIL prio_no_write got=%b/%h exp=1/00000100", v, d); end
  endtask

  task automatic test_reset_abort;
    int fd = 0;
    logic v;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) cpu_write(12, i, 4'hF, 32'(32'hA0 + i));
    bus.fill_start = 1; bus.fill_index = 6'd12;
    @(negedge clk);
    bus.fill_start = 0;
    for (int i = 0; i < 3; i++) begin
      bus.fill_valid = 1; bus.fill_data = 32'(32'hB0 + i);
      @(negedge clk);
    end
    bus.fill_valid = 0;
    srst_n = 0;
    #1;
    checks++;
    if ({bus.cpu_gnt, bus.cpu_rvalid, bus.fill_ready, bus.fill_done, bus.evict_valid, bus.evict_done, bus.busy} !== 7'b0) begin
      errors++; $display("FAIL abort_flags got=%b exp=0000000", {bus.cpu_gnt, bus.cpu_rvalid, bus.fill_ready, bus.fill_done, bus.evict_valid, bus.evict_done, bus.busy});
    end
    checks++;
    if (bus.cpu_rdata !== 32'h0 || bus.evict_data !== 32'h0) begin
      errors++; $display("FAIL abort_data rdata/evict_data got=%h/%h exp=0/0", bus.cpu_rdata, bus.evict_data);
    end
    @(negedge clk);
    srst_n = 1;
    repeat (3) begin @(negedge clk); fd += int'(bus.fill_done); end
    checks++;
    if (fd != 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_done got=%0d/%b exp=0/0", fd, bus.busy); end
    for (int i = 0; i < 8; i++) begin
      cpu_read(12, i, v, d);
      checks++;
      if (v !== 1'b1 || d !== (i < 3 ? 32'(32'hB0 + i) : 32'(32'hA0 + i))) begin
        errors++; $display("FAIL abort_word%0d got=%b/%h exp=1/%h", i, v, d, (i < 3 ? 32'(32'hB0 + i) : 32'(32'hA0 + i)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_fill();
    test_evict();
    test_priority();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
